// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master: APB master that turns single config commands into CCC register
// accesses, optionally waiting for a stable PLL lock after the last write of a reconfiguration.
module ccc_apb_cfg_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LOCK_STABLE    = 16
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WRITE,
  input  logic       CMD_LAST,
  input  logic [5:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  input  logic       LOCK,
  output logic       LOCKED
);
  localparam int MAXC = (TIMEOUT_CYCLES > LOCK_STABLE) ? TIMEOUT_CYCLES : LOCK_STABLE;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_LOCK, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, stab_q;
  logic last_q;
  logic acc_done, acc_to, lock_ok, lock_to, to_lock;
  assign acc_done = (state_q == ACCESS) && !BUSY;
  assign acc_to   = (state_q == ACCESS) && BUSY && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign to_lock  = acc_done && PWRITE && last_q;
  // lock success wins over a timeout landing on the same cycle
  assign lock_ok  = (state_q == WAIT_LOCK) && LOCK && (stab_q == CW'(LOCK_STABLE - 1));
  assign lock_to  = (state_q == WAIT_LOCK) && !lock_ok && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge PCLK) begin
    if (!PRESET_N) state_q <= IDLE;
    else           state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = CMD_VALID ? SETUP : IDLE;
      SETUP:     state_d = ACCESS;
      ACCESS:    state_d = to_lock ? WAIT_LOCK : (acc_done || acc_to) ? RESP : ACCESS;
      WAIT_LOCK: state_d = (lock_ok || lock_to) ? RESP : WAIT_LOCK;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    CMD_READY = (state_q == IDLE) && PRESET_N;
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    RSP_VALID = (state_q == RESP);
  end
  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      stab_q    <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      LOCKED    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && CMD_VALID) begin
        PWRITE <= CMD_WRITE;
        last_q <= CMD_LAST;
        PADDR  <= CMD_ADDR;
        PWDATA <= CMD_WDATA;
      end
      cnt_q  <= (state_d != state_q || !(state_q == ACCESS || state_q == WAIT_LOCK)) ? '0 :
                (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      stab_q <= (state_q == WAIT_LOCK && state_d == WAIT_LOCK && LOCK) ?
                ((&stab_q) ? stab_q : stab_q + 1'b1) : '0;
      if (acc_done && !to_lock) begin
        RSP_RDATA <= PWRITE ? 8'h00 : PRDATA;
        RSP_ERR   <= 1'b0;
      end
      if (acc_to || lock_to) begin
        RSP_RDATA <= 8'h00;
        RSP_ERR   <= 1'b1;
      end
      if (lock_ok) begin
        RSP_RDATA <= 8'h00;
        RSP_ERR   <= 1'b0;
        LOCKED    <= 1'b1;
      end
      if (to_lock) LOCKED <= 1'b0;
    end
  end
endmodule
